// File: rtl/pipe_ctrl_decoder.sv
// ============================================================================
// Module   : pipe_ctrl_decoder
// Brief    : Pipelined opcode-to-control decoder with stall/flush and a
//            return-shadow nullification counter. Optional macro
//            SPLIT_BUSA_EN decodes busD-to-busA independently of busB.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_ctrl_decoder #(
  parameter int OPC_W      = 8,
  parameter int DEPTH      = 2,
  parameter int NILL_SLOTS = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [OPC_W-1:0] in_opc,
  output logic             in_ready,
  input  logic             stall,
  input  logic             flush,
  output logic             out_valid,
  output logic [OPC_W-1:0] out_opc,
  output logic             out_wr_rf,
  output logic             out_dst_valid,
  output logic             out_load,
  output logic             out_busd_to_b,
  output logic             out_busd_to_a,
  output logic             out_ret,
  output logic             out_nullified
);

  localparam int c_fw = OPC_W - 3;
  localparam int c_cw = $clog2(NILL_SLOTS + 1);

  logic [DEPTH-1:0] r_valid;
  logic [OPC_W-1:0] r_opc [DEPTH];
  logic [c_cw-1:0]  r_cnt;
  logic             r_wr_rf, r_dst_valid, r_load, r_busd_to_b, r_busd_to_a;
  logic             r_ret, r_nullified;

  logic             w_last_valid;
  logic [OPC_W-1:0] w_last_opc;
  logic             w_live, w_alu, w_ld, w_st, w_ctrl;
  logic [1:0]       w_cls;
  logic [c_fw-1:0]  w_func;
  logic             w_dec_wr_rf, w_dec_dst, w_dec_b, w_dec_a, w_dec_ret;
  logic             w_shadow, w_keep;

  // Decoding happens on whatever is about to enter the final stage.
  generate
    if (DEPTH == 1) begin : g_last_in_direct
      assign w_last_valid = in_valid;
      assign w_last_opc   = in_opc;
    end else begin : g_last_in_stage
      assign w_last_valid = r_valid[DEPTH-2];
      assign w_last_opc   = r_opc[DEPTH-2];
    end
  endgenerate

  always_comb begin
    w_live      = w_last_opc[OPC_W-1];
    w_cls       = w_last_opc[OPC_W-2 -: 2];
    w_func      = w_last_opc[c_fw-1:0];
    w_alu       = w_live & (w_cls == 2'b00);
    w_ld        = w_live & (w_cls == 2'b01);
    w_st        = w_live & (w_cls == 2'b10);
    w_ctrl      = w_live & (w_cls == 2'b11);
    w_dec_wr_rf = w_alu | w_ld | (w_ctrl & w_func[c_fw-1]);
    // All-ones func on an ALU op is the NOP: writes nothing meaningful.
    w_dec_dst   = w_dec_wr_rf & ~(w_alu & (&w_func));
    w_dec_b     = w_st | (w_alu & w_func[c_fw-2]);
`ifdef SPLIT_BUSA_EN
    w_dec_a     = (w_st & w_func[0]) | (w_alu & w_func[c_fw-3]);
`else
    w_dec_a     = w_dec_b;
`endif
    w_dec_ret   = w_ctrl & (w_func == '0);
  end

  assign w_shadow = (r_cnt != '0);
  assign w_keep   = w_last_valid & ~w_shadow;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      for (int i = 0; i < DEPTH; i++) r_opc[i] <= '0;
      r_cnt       <= '0;
      r_wr_rf     <= 1'b0;
      r_dst_valid <= 1'b0;
      r_load      <= 1'b0;
      r_busd_to_b <= 1'b0;
      r_busd_to_a <= 1'b0;
      r_ret       <= 1'b0;
      r_nullified <= 1'b0;
    end else if (flush) begin
      r_valid     <= '0;
      r_cnt       <= '0;
      r_wr_rf     <= 1'b0;
      r_dst_valid <= 1'b0;
      r_load      <= 1'b0;
      r_busd_to_b <= 1'b0;
      r_busd_to_a <= 1'b0;
      r_ret       <= 1'b0;
      r_nullified <= 1'b0;
    end else if (!stall) begin
      r_valid[0] <= in_valid;
      r_opc[0]   <= in_opc;
      for (int i = 1; i < DEPTH; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_opc[i]   <= r_opc[i-1];
      end
      r_wr_rf     <= w_keep & w_dec_wr_rf;
      r_dst_valid <= w_keep & w_dec_dst;
      r_load      <= w_keep & w_ld;
      r_busd_to_b <= w_keep & w_dec_b;
      r_busd_to_a <= w_keep & w_dec_a;
      r_ret       <= w_keep & w_dec_ret;
      r_nullified <= w_last_valid & w_shadow;
      // Bubbles leave the counter alone; a ret inside the shadow never reloads.
      if (w_last_valid) begin
        if (w_shadow)
          r_cnt <= r_cnt - 1'b1;
        else if (w_dec_ret)
          r_cnt <= c_cw'(NILL_SLOTS);
      end
    end
  end

  assign in_ready      = ~stall;
  assign out_valid     = r_valid[DEPTH-1];
  assign out_opc       = r_opc[DEPTH-1];
  assign out_wr_rf     = r_wr_rf;
  assign out_dst_valid = r_dst_valid;
  assign out_load      = r_load;
  assign out_busd_to_b = r_busd_to_b;
  assign out_busd_to_a = r_busd_to_a;
  assign out_ret       = r_ret;
  assign out_nullified = r_nullified;

endmodule

`default_nettype wire
